// File: rtl/gen_rw_pkg.sv
// Shared types and helpers for the generic reader/writer traffic generator.
// Used by the AW/B handler and reused by the AR/R side.
package gen_rw_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int ID_W       = 4;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [8:0]            len;        // beats per transaction
    logic [15:0]           burst_len;  // transactions per job
    logic [2:0]            size;
    logic [ID_W-1:0]       id;
  } trans_data_t;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic [3:0]            cache;
    logic [2:0]            prot;
  } aw_channel_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_channel_t;

  // Byte offset of transaction idx within a job; wraps modulo 2^AXI_ADDR_W.
  function automatic logic [AXI_ADDR_W-1:0] aw_offset(input logic [15:0] idx,
                                                      input logic [8:0]  len,
                                                      input logic [2:0]  size);
    logic [AXI_ADDR_W-1:0] bytes;
    bytes = AXI_ADDR_W'(len) << size;
    return AXI_ADDR_W'(idx) * bytes;
  endfunction

endpackage

// File: rtl/outstanding_cnt.sv
// Saturating up/down counter of in-flight requests with full/empty flags.
// A decrement while empty is reported as underflow and leaves the count alone.
module outstanding_cnt #(
  parameter  int MAX = 4,
  localparam int CW  = $clog2(MAX+1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          underflow_o
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          inc_ok, dec_ok;

  assign empty_o     = (cnt_q == '0);
  assign full_o      = (cnt_q == CW'(MAX));
  assign underflow_o = dec_i && empty_o;
  assign dec_ok      = dec_i && !empty_o;
  assign inc_ok      = inc_i && (!full_o || dec_ok);
  assign count_o     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_ok && !dec_ok)      cnt_d = cnt_q + CW'(1);
    else if (dec_ok && !inc_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/aw_handler.sv
// Write-address stage: issues burst_len AW requests with incrementing addresses,
// bounds in-flight writes, consumes B responses and reports done/error.
module aw_handler
  import gen_rw_pkg::*;
#(
  parameter int ADDR_WIDTH      = AXI_ADDR_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  output logic                               aw_valid_o,
  output aw_channel_t                        aw_data_o,
  input  logic                               aw_ready_i,
  input  logic                               b_valid_i,
  input  b_channel_t                         b_data_i,
  output logic                               b_ready_o,
  input  trans_data_t                        trans_data_i,
  input  logic                               enable_i,
  output logic                               ready_o,
  output logic                               done_o,
  output logic                               error_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = {AXI_ADDR_W{1'b1}} >> (AXI_ADDR_W - ADDR_WIDTH);

  state_e      state_q, state_d;
  trans_data_t desc_q, desc_d;
  logic [15:0] issued_q, issued_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        aw_hs, b_hs, cnt_full, cnt_empty, cnt_uflow;
  logic        unused_b_id;

  // Responses are counted, not matched against request ids.
  assign unused_b_id = ^b_data_i.id;

  // Count only drops while valid waits, so gating on full never retracts valid.
  assign aw_valid_o = (state_q == ISSUE) && !cnt_full;
  assign b_ready_o  = (state_q != IDLE);
  assign ready_o    = (state_q == IDLE);
  assign done_o     = done_q;
  assign error_o    = err_q;
  assign aw_hs      = aw_valid_o && aw_ready_i;
  assign b_hs       = b_valid_i && b_ready_o;

  outstanding_cnt #(.MAX(MAX_OUTSTANDING)) u_cnt (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (aw_hs),
    .dec_i       (b_hs),
    .count_o     (outstanding_o),
    .full_o      (cnt_full),
    .empty_o     (cnt_empty),
    .underflow_o (cnt_uflow)
  );

  always_comb begin
    aw_data_o       = '0;
    aw_data_o.id    = desc_q.id;
    aw_data_o.addr  = (desc_q.addr + aw_offset(issued_q, desc_q.len, desc_q.size)) & ADDR_MASK;
    aw_data_o.len   = 8'(desc_q.len - 9'd1);
    aw_data_o.size  = desc_q.size;
    aw_data_o.burst = BURST_INCR;
  end

  always_comb begin
    state_d  = state_q;
    desc_d   = desc_q;
    issued_d = issued_q;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      IDLE: if (enable_i) begin
        desc_d   = trans_data_i;
        issued_d = '0;
        err_d    = 1'b0;
        state_d  = (trans_data_i.burst_len == 16'd0) ? DRAIN : ISSUE;
      end
      ISSUE: if (aw_hs) begin
        issued_d = issued_q + 16'd1;
        if (issued_q == desc_q.burst_len - 16'd1) state_d = DRAIN;
      end
      DRAIN: if (cnt_empty) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (b_hs && (cnt_uflow || b_data_i.resp != RESP_OKAY)) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      desc_q   <= '0;
      issued_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      desc_q   <= desc_d;
      issued_q <= issued_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_aw_handler.sv
// Scoreboard bench for aw_handler: driver queues expected AWs and done/error,
// a monitor checks them, and a responder returns B beats under credit control.
module tb_aw_handler;
  import gen_rw_pkg::*;

  localparam int MAXO = 4;
  localparam int OW   = $clog2(MAXO+1);

  typedef struct {
    int              due;
    logic [1:0]      resp;
    logic [ID_W-1:0] id;
  } bent_t;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        aw_valid_o, aw_ready_i, b_valid_i, b_ready_o;
  aw_channel_t aw_data_o;
  b_channel_t  b_data_i;
  trans_data_t trans_data_i;
  logic        enable_i, ready_o, done_o, error_o;
  logic [OW-1:0] outstanding_o;

  aw_channel_t exp_aw[$];
  logic        exp_done[$];
  bent_t       b_q[$];

  int checks = 0, errors = 0, cyc = 0;
  int aw_total = 0, done_cnt = 0;
  int b_sent = 0, b_limit = 1000000;
  int spur_req = 0, spur_sent = 0;
  int err_aw_idx = -1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aw_handler #(.ADDR_WIDTH(32), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .aw_valid_o    (aw_valid_o),
    .aw_data_o     (aw_data_o),
    .aw_ready_i    (aw_ready_i),
    .b_valid_i     (b_valid_i),
    .b_data_i      (b_data_i),
    .b_ready_o     (b_ready_o),
    .trans_data_i  (trans_data_i),
    .enable_i      (enable_i),
    .ready_o       (ready_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .outstanding_o (outstanding_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_outputs();
    chk("rst aw_valid", aw_valid_o, 0);
    chk("rst b_ready", b_ready_o, 0);
    chk("rst done", done_o, 0);
    chk("rst error", error_o, 0);
    chk("rst outstanding", outstanding_o, 0);
    chk("rst ready", ready_o, 1);
  endtask

  task automatic start_job(input logic [31:0] addr, input int len, input int size,
                           input int bl, input int id, input logic want_done,
                           input logic exp_err);
    trans_data_t d;
    aw_channel_t a;
    int n;
    n = 0;
    while (!ready_o && n < 200) begin tick(); n++; end
    chk("ready before job", ready_o, 1);
    d.addr = addr; d.len = 9'(len); d.burst_len = 16'(bl);
    d.size = 3'(size); d.id = 4'(id);
    for (int i = 0; i < bl; i++) begin
      a = '0;
      a.id    = d.id;
      a.addr  = addr + 32'(i * len * (1 << size));
      a.len   = 8'(len - 1);
      a.size  = d.size;
      a.burst = 2'b01;
      exp_aw.push_back(a);
    end
    if (want_done) exp_done.push_back(exp_err);
    trans_data_i = d;
    enable_i = 1'b1;
    tick();
    enable_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int base, n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < bound) begin tick(); n++; end
    chk(name, done_cnt > base, 1);
  endtask

  // Monitor: samples mid-cycle, i.e. the values that the next rising edge commits.
  initial begin : monitor
    aw_channel_t prev, e;
    bent_t       be;
    logic        stall, ed;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst_i) begin stall = 1'b0; continue; end
      if (stall) begin
        chk("aw_valid held", aw_valid_o, 1);
        chk("aw_data held", aw_data_o, prev);
      end
      stall = aw_valid_o && !aw_ready_i;
      prev  = aw_data_o;
      if (aw_valid_o && aw_ready_i) begin
        chk("aw was expected", exp_aw.size() != 0, 1);
        if (exp_aw.size() != 0) begin
          e = exp_aw.pop_front();
          chk("aw payload", aw_data_o, e);
        end
        be.due  = cyc + 2;
        be.resp = (aw_total == err_aw_idx) ? 2'b10 : 2'b00;
        be.id   = aw_data_o.id;
        b_q.push_back(be);
        aw_total++;
      end
      if (done_o) begin
        chk("done was expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          ed = exp_done.pop_front();
          chk("error at done", error_o, ed);
        end
        chk("aws left at done", exp_aw.size(), 0);
        done_cnt++;
      end
    end
  end

  // B responder: one beat at a time, limited by b_limit credits; spur_req injects unsolicited B.
  initial begin : responder
    bent_t e;
    logic  hs;
    b_valid_i = 1'b0;
    b_data_i  = '0;
    forever begin
      @(negedge clk);
      hs = b_valid_i && b_ready_o;
      @(posedge clk);
      #1;
      if (rst_i) begin
        b_q.delete();
        b_valid_i = 1'b0;
      end else begin
        if (hs) b_valid_i = 1'b0;
        if (!b_valid_i) begin
          if (spur_sent < spur_req) begin
            b_data_i.id = '0; b_data_i.resp = RESP_OKAY;
            b_valid_i = 1'b1;
            spur_sent++;
          end else if (b_q.size() != 0 && b_q[0].due <= cyc && b_sent < b_limit) begin
            e = b_q.pop_front();
            b_data_i.id = e.id; b_data_i.resp = e.resp;
            b_valid_i = 1'b1;
            b_sent++;
          end
        end
      end
    end
  end

  initial begin : driver
    int base, n;
    rst_i = 1'b1; enable_i = 1'b0; aw_ready_i = 1'b0; trans_data_i = '0;
    repeat (3) tick();
    rst_i = 1'b0;
    check_reset_outputs();

    // basic job: 0x1000/0x1010/0x1020, len field 3
    aw_ready_i = 1'b1;
    start_job(32'h1000, 4, 2, 3, 5, 1'b1, 1'b0);
    chk("ready low in job", ready_o, 0);
    wait_done("basic done", 100);
    chk("done single cycle", done_o, 0);
    chk("ready after done", ready_o, 1);

    // outstanding limit with B withheld
    b_limit = b_sent; base = aw_total;
    start_job(32'h2000, 1, 0, 6, 1, 1'b1, 1'b0);
    repeat (10) tick();
    chk("aw count at limit", aw_total - base, 4);
    chk("valid low at limit", aw_valid_o, 0);
    chk("outstanding at limit", outstanding_o, 4);
    b_limit = b_sent + 1;
    repeat (4) tick();
    chk("aw after one B", aw_total - base, 5);
    chk("outstanding refilled", outstanding_o, 4);
    b_limit = 1000000;
    wait_done("limit done", 200);

    // backpressure on the second AW for 5 cycles
    base = aw_total;
    start_job(32'h3000, 2, 3, 3, 2, 1'b1, 1'b0);
    n = 0;
    while (aw_total - base < 1 && n < 20) begin tick(); n++; end
    aw_ready_i = 1'b0;
    repeat (5) tick();
    chk("no aw during stall", aw_total - base, 1);
    aw_ready_i = 1'b1;
    wait_done("backpressure done", 100);

    // same-cycle AW and B handshakes at outstanding 2
    aw_ready_i = 1'b0; b_limit = b_sent; base = aw_total;
    start_job(32'h5000, 8, 1, 4, 3, 1'b1, 1'b0);
    aw_ready_i = 1'b1;
    tick(); tick();
    aw_ready_i = 1'b0;
    repeat (4) tick();
    chk("outstanding before sim", outstanding_o, 2);
    b_limit = b_sent + 1;
    n = 0;
    while (!b_valid_i && n < 10) begin tick(); n++; end
    aw_ready_i = 1'b1;
    tick();
    aw_ready_i = 1'b0;
    chk("outstanding after sim", outstanding_o, 2);
    chk("aw count after sim", aw_total - base, 3);
    aw_ready_i = 1'b1; b_limit = 1000000;
    wait_done("sim done", 100);

    // error response on the second B, sticky through done
    err_aw_idx = aw_total + 1;
    start_job(32'h7000, 1, 2, 2, 6, 1'b1, 1'b1);
    wait_done("error job done", 100);
    chk("error sticky", error_o, 1);
    err_aw_idx = -1;

    // burst_len 0: no AW, enable clears error, done on the next cycle
    start_job(32'h8000, 4, 2, 0, 0, 1'b1, 1'b0);
    chk("error cleared", error_o, 0);
    tick();
    chk("zero-len done", done_o, 1);
    tick();

    // unsolicited B while draining at count 0
    spur_req++;
    start_job(32'h9000, 4, 2, 0, 0, 1'b1, 1'b1);
    wait_done("spurious done", 20);
    chk("error after spurious B", error_o, 1);

    // address wrap: 0xFFFF_FFF0 then 0x0000_0000
    start_job(32'hFFFF_FFF0, 4, 2, 2, 7, 1'b1, 1'b0);
    wait_done("wrap done", 100);

    // reset in the middle of ISSUE
    b_limit = b_sent;
    start_job(32'hA000, 1, 0, 8, 1, 1'b0, 1'b0);
    repeat (8) tick();
    chk("outstanding before reset", outstanding_o, 4);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_outputs();
    exp_aw.delete();
    b_limit = 1000000;

    // recovery after reset
    start_job(32'h40, 1, 0, 1, 2, 1'b1, 1'b0);
    wait_done("recovery done", 100);
    tick();
    chk("all done events seen", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
